// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side logic.
// State encoding, default timing values and frame edge indices live here.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int unsigned DEF_CLK_HZ         = 25_000_000;
  localparam int unsigned DEF_INHIBIT_CYCLES = DEF_CLK_HZ / 10_000;
  localparam int unsigned DEF_START_TIMEOUT  = DEF_CLK_HZ / 66;
  localparam int unsigned DEF_BIT_TIMEOUT    = DEF_CLK_HZ / 500;

  localparam int TMR_W  = 20;
  localparam int EDGE_W = 4;

  // Device falling-edge numbers within one host-to-device frame.
  localparam logic [EDGE_W-1:0] PARITY_EDGE = 4'd9;
  localparam logic [EDGE_W-1:0] STOP_EDGE   = 4'd10;
  localparam logic [EDGE_W-1:0] ACK_EDGE    = 4'd11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data pads, plus a
// one-cycle strobe on each synchronized clock falling edge.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic fall_o
);

  logic clk_meta_q;
  logic clk_s_q;
  logic clk_prev_q;
  logic data_meta_q;
  logic data_s_q;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_meta_q  <= 1'b1;
      clk_s_q     <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_s_q    <= 1'b1;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_s_q     <= clk_meta_q;
      clk_prev_q  <= clk_s_q;
      data_meta_q <= ps2_data_i;
      data_s_q    <= data_meta_q;
    end
  end

  assign clk_s_o  = clk_s_q;
  assign data_s_o = data_s_q;
  assign fall_o   = clk_prev_q & ~clk_s_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over the
// open-drain kbclk/kbdata pair and reports the device ACK or a timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned INHIBIT_CYCLES = CLK_HZ / 10_000,
  parameter int unsigned START_TIMEOUT  = CLK_HZ / 66,
  parameter int unsigned BIT_TIMEOUT    = CLK_HZ / 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_ack,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output ps2_state_e state_o
);

  // Handshake: a byte is taken on any rising clk edge where tx_valid and
  // tx_ready are both high; tx_ready is high only in IDLE, and requests seen
  // while busy are dropped rather than queued.

  localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] BIT_LAST   = TMR_W'(BIT_TIMEOUT - 1);

  logic clk_s;
  logic data_s;
  logic fall;

  ps2_line_sync u_sync (
    .clk_i      (clk),
    .rst_i      (reset),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .fall_o     (fall)
  );

  ps2_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [EDGE_W-1:0] edge_nx;
  logic [8:0]        shift_q, shift_d;
  logic              data_oe_q, data_oe_d;
  logic              rts_q, rts_d;
  logic              ack_q, ack_d;
  logic              done;
  logic              err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      edge_q    <= '0;
      shift_q   <= '0;
      data_oe_q <= 1'b0;
      rts_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      edge_q    <= edge_d;
      shift_q   <= shift_d;
      data_oe_q <= data_oe_d;
      rts_q     <= rts_d;
      ack_q     <= ack_d;
    end
  end

  assign edge_nx = edge_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + 1'b1;
    edge_d    = edge_q;
    shift_d   = shift_q;
    data_oe_d = data_oe_q;
    rts_d     = rts_q;
    ack_d     = ack_q;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmr_d     = '0;
        data_oe_d = 1'b0;
        rts_d     = 1'b0;
        if (tx_valid) begin
          shift_d = {odd_parity(tx_data), tx_data};
          edge_d  = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        // Pull data low at terminal count, keep clock low one more cycle.
        if (rts_q) begin
          state_d = REQ;
        end else if (tmr_q == INH_LAST) begin
          rts_d     = 1'b1;
          data_oe_d = 1'b1;
        end
      end
      REQ: begin
        if (fall) begin
          edge_d    = 4'd1;
          data_oe_d = ~shift_q[0];
          shift_d   = shift_q >> 1;
          state_d   = SEND;
        end else if (tmr_q == START_LAST) begin
          err = 1'b1;
        end
      end
      SEND: begin
        if (fall) begin
          edge_d = edge_nx;
          tmr_d  = '0;
          if (edge_nx == STOP_EDGE) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            // Edges 2..8 shift out data bits, PARITY_EDGE shifts out parity.
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else if (tmr_q == BIT_LAST) begin
          err = 1'b1;
        end
      end
      ACK: begin
        if (fall) begin
          edge_d  = ACK_EDGE;
          ack_d   = ~data_s;
          state_d = WAIT_IDLE;
        end else if (tmr_q == BIT_LAST) begin
          err = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (tmr_q == BIT_LAST) begin
          err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (err) begin
      state_d   = IDLE;
      data_oe_d = 1'b0;
      rts_d     = 1'b0;
    end

    // One timer serves every waiting state, so restart it on each move.
    if (state_d != state_q) tmr_d = '0;
  end

  assign tx_ready    = (state_q == IDLE);
  assign tx_done     = done;
  assign tx_err      = err;
  assign tx_ack      = ack_q;
  assign ps2_clk_oe  = (state_q == INHIBIT);
  assign ps2_data_oe = data_oe_q;
  assign state_o     = state_q;

  a_done_err_excl: assert property (@(posedge clk) disable iff (reset)
    !(tx_done && tx_err));
  a_idle_lines_free: assert property (@(posedge clk) disable iff (reset)
    (state_q == IDLE) |-> !data_oe_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with a behavioural open-drain keyboard.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_HZ   = 25_000_000;
  localparam int INH      = 2500;
  localparam int START_TO = 3000;
  localparam int BIT_TO   = 600;
  localparam int HALF     = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_ack, tx_err;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       kb_clk, kb_data;
  ps2_state_e dut_state;

  assign kb_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign kb_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_HZ         (CLK_HZ),
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (START_TO),
    .BIT_TIMEOUT    (BIT_TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_ack      (tx_ack),
    .tx_err      (tx_err),
    .ps2_clk_in  (kb_clk),
    .ps2_data_in (kb_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .state_o     (dut_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cnt = 0;
  always @(posedge clk) if (!reset && tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;

  // ---------------- scoreboard ----------------
  int cmp_cnt = 0;
  int mis_cnt = 0;
  logic [1:0]  exp_q[$];
  logic [10:0] frame_q[$];
  int err_cyc = 0;
  int req_cyc = 0;
  int fall5_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    cmp_cnt++;
    if (act < lo || act > hi) begin
      mis_cnt++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Completion monitor: every done/err pulse must match the next expectation.
  always @(negedge clk) begin
    if (!reset && (tx_done || tx_err)) begin
      if (tx_err) err_cyc = cyc;
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        mis_cnt++;
        $display("FAIL unexpected_event: done=%b err=%b with nothing expected", tx_done, tx_err);
      end else begin
        check("response_err_ack", 32'({tx_err, tx_err ? 1'b0 : tx_ack}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [7:0] d, input bit hold);
    bit took = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready) begin
        took = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!took) check("accept_seen", 32'(0), 32'(1));
    if (!hold) tx_valid = 1'b0;
  endtask

  // mode 0: full frame, 1: never clocks, 2: stops after edge 5, 3: stops after edge 4
  task automatic device_run(input int mode, input bit ack);
    logic [10:0] fr = '0;
    int   inh = 0;
    logic last_doe = 1'b0;
    bit   seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ps2_clk_oe) seen = 1;
    end
    if (!seen) begin
      check("inhibit_start_seen", 32'(0), 32'(1));
      return;
    end
    while (ps2_clk_oe && inh < 20000) begin
      last_doe = ps2_data_oe;
      inh++;
      @(negedge clk);
    end
    req_cyc = cyc;
    check_range("inhibit_len", inh, INH, INH + 2);
    check("data_low_before_clk_release", 32'(last_doe), 32'(1));
    fr[0] = kb_data;
    if (mode == 1) return;
    for (int n = 1; n <= 10; n++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      if (n == 5) fall5_cyc = cyc;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      fr[n] = kb_data;
      if (mode == 2 && n == 5) return;
      if (mode == 3 && n == 4) return;
    end
    if (frame_q.size() == 0) check("frame_expectation_present", 32'(0), 32'(1));
    else check("device_frame", 32'(fr), 32'(frame_q.pop_front()));
    repeat (HALF) @(negedge clk);
    if (ack) dev_data_low = 1'b1;
    repeat (5) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_resp(input string name);
    bool_wait: for (int i = 0; i < 30000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      cmp_cnt++;
      mis_cnt++;
      $display("FAIL %s_timeout: %0d responses still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_ready"}, 32'(tx_ready), 32'(1));
    check({name, "_clk_oe"}, 32'(ps2_clk_oe), 32'(0));
    check({name, "_data_oe"}, 32'(ps2_data_oe), 32'(0));
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [10:0] frame_exp, input bit ack);
    exp_q.push_back({1'b0, ack});
    frame_q.push_back(frame_exp);
    fork
      drive_req(d, 1'b0);
      device_run(0, ack);
    join
    wait_resp("frame_done");
    @(negedge clk);
    check_idle("after_frame");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acc0;
    bit got_done;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(tx_ready), 32'(1));
    check("reset_done", 32'(tx_done), 32'(0));
    check("reset_ack", 32'(tx_ack), 32'(0));
    check("reset_err", 32'(tx_err), 32'(0));
    check("reset_clk_oe", 32'(ps2_clk_oe), 32'(0));
    check("reset_data_oe", 32'(ps2_data_oe), 32'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // frame = {stop, parity, data[7:0], start}
    run_frame(8'hED, 11'h7DA, 1'b1);
    run_frame(8'hF4, 11'h5E8, 1'b1);
    run_frame(8'h00, 11'h600, 1'b1);
    run_frame(8'hED, 11'h7DA, 1'b0);

    // Device never answers the request.
    exp_q.push_back(2'b10);
    fork
      drive_req(8'hF4, 1'b0);
      device_run(1, 1'b1);
    join
    wait_resp("start_timeout");
    check_range("start_timeout_cycles", err_cyc - req_cyc, START_TO - 3, START_TO + 3);
    @(negedge clk);
    check_idle("after_start_timeout");

    // Device stalls after edge 5.
    exp_q.push_back(2'b10);
    fork
      drive_req(8'hED, 1'b0);
      device_run(2, 1'b1);
    join
    wait_resp("bit_timeout");
    check_range("bit_timeout_cycles", err_cyc - fall5_cyc, BIT_TO, BIT_TO + 6);
    @(negedge clk);
    check_idle("after_bit_timeout");

    // Reset in the middle of SEND, away from any clock edge.
    fork
      drive_req(8'h00, 1'b0);
      device_run(3, 1'b1);
    join
    @(negedge clk);
    check("pre_reset_state", 32'(dut_state), 32'(SEND));
    check("pre_reset_data_oe", 32'(ps2_data_oe), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("async_reset_clk_oe", 32'(ps2_clk_oe), 32'(0));
    check("async_reset_data_oe", 32'(ps2_data_oe), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_ready", 32'(tx_ready), 32'(1));

    // tx_valid held across the whole frame, including the tx_done cycle.
    acc0 = acc_cnt;
    exp_q.push_back(2'b01);
    frame_q.push_back(11'h7DA);
    fork
      drive_req(8'hED, 1'b1);
      device_run(0, 1'b1);
    join
    got_done = 0;
    for (int i = 0; i < 2000 && !got_done; i++) begin
      @(negedge clk);
      if (tx_done) got_done = 1;
    end
    tx_valid = 1'b0;
    check("held_valid_done_seen", 32'(got_done), 32'(1));
    repeat (3) @(negedge clk);
    check("held_valid_accepts", 32'(acc_cnt - acc0), 32'(1));
    wait_resp("held_valid");
    check_idle("after_held_valid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  initial begin
    #900_000;
    mis_cnt++;
    $display("FAIL watchdog: simulation time limit reached, expected sequence to finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
